modulus_sweep_seq: RTL

Operand sequencer and result buffer for the combinational `integer_division_modulus` stage. On a start pulse it drives every operand `a` from START to STOP inclusive into the modulus stage, one per accepted slot. It pairs each operand with the returned remainder `r` and emits the pairs as a valid/ready stream through a 2-entry buffer. It sits directly upstream and downstream of the modulus stage and replaces free-running testbench stimulus in synthesizable sweeps.

---
 rtl/modsweep_pkg.sv | 31 +++
 rtl/modsweep_fifo2.sv | 72 +++++++
 rtl/modulus_sweep_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/modsweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modsweep_pkg
// Description : Shared types and default constants for the modulus sweep
//               sequencer (FSM state encoding, operand/remainder pair,
//               default sweep bounds).
// Revision    : 1.0 - initial release
// ============================================================================
package modsweep_pkg;

    localparam int          DEF_WIDTH   = 32;
    localparam logic [31:0] DEF_START   = 32'd1234101;
    localparam logic [31:0] DEF_STOP    = 32'd2468202;
    localparam logic [31:0] DEF_DIVISOR = 32'd1234101;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operand/remainder pair at the default width
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] r;
    } pair_t;

endpackage : modsweep_pkg
`default_nettype wire

// File: rtl/modsweep_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : modsweep_fifo2
// Description : Two-entry FIFO built as a head/tail register pair. The head
//               register drives the output directly, so the output data and
//               the occupancy flags are purely registered. Push and pop may
//               happen in the same cycle at any occupancy, including full.
// Revision    : 1.0 - initial release
// ============================================================================
module modsweep_fifo2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic              single
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        fill;
    logic              do_pop;
    logic              do_push;

    // A pop of an empty FIFO or a push into a full FIFO without a pop are dropped
    assign do_pop  = pop  && (fill != 2'd0);
    assign do_push = push && ((fill != 2'd2) || do_pop);

    assign head_data = head_q;
    assign full      = (fill == 2'd2);
    assign empty     = (fill == 2'd0);
    assign single    = (fill == 2'd1);

    // Occupancy and entry storage; the head always holds the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (fill == 2'd0) begin
                        head_q <= push_data;
                    end else begin
                        tail_q <= push_data;
                    end
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    fill   <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : modsweep_fifo2
`default_nettype wire

// File: rtl/modulus_sweep_seq.sv
`default_nettype none
// ============================================================================
// Module      : modulus_sweep_seq
// Description : Operand sequencer and result buffer for an external
//               combinational modulus stage. Sweeps a_out from START to STOP
//               inclusive, pairs each operand with the returned remainder and
//               streams the pairs out through a 2-entry FIFO.
//               Optional feature macro: MODSWEEP_CHECK_EN adds a sticky err
//               flag raised when a pushed remainder is not below DIVISOR.
// Revision    : 1.0 - initial release
// ============================================================================
module modulus_sweep_seq
    import modsweep_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] START   = WIDTH'(DEF_START),
    parameter logic [WIDTH-1:0] STOP    = WIDTH'(DEF_STOP),
    parameter logic [WIDTH-1:0] DIVISOR = WIDTH'(DEF_DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] r_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_a,
    output logic [WIDTH-1:0] m_r,
    output logic [WIDTH-1:0] count
`ifdef MODSWEEP_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] r;
    } pair_w_t;

    state_t  state;
    pair_w_t push_pair;
    pair_w_t head_pair;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_single;
    logic    push;
    logic    pop;
    logic    drain_empty_next;

    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    // A full buffer still accepts a push when its head leaves in the same cycle
    assign push      = (state == ST_RUN) && (!fifo_full || pop);
    assign push_pair = {a_out, r_in};
    assign m_a       = head_pair.a;
    assign m_r       = head_pair.r;

    // The buffer is empty after this edge: either already empty or the last entry leaves now
    assign drain_empty_next = fifo_empty || (fifo_single && pop);

    modsweep_fifo2 #(
        .DATA_W (2*WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_pair),
        .head_data (head_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .single    (fifo_single)
    );

    // Sweep FSM with registered a_out, busy, done and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_out <= START;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            if (pop && (count != '1)) begin
                count <= count + WIDTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    a_out <= START;
                    if (start) begin
                        count <= '0;
                        // An empty range completes immediately with no pairs
                        if (START > STOP) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        // Equality test before incrementing keeps STOP = all-ones from wrapping
                        if (a_out == STOP) begin
                            a_out <= START;
                            state <= ST_DRAIN;
                        end else begin
                            a_out <= a_out + WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty_next) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MODSWEEP_CHECK_EN
    // Sticky range check on every pushed remainder, cleared by a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            err <= 1'b0;
        end else if (push && !(r_in < DIVISOR)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : modulus_sweep_seq
`default_nettype wire
